// File: rtl/crc_frame_appender.sv
// crc_frame_appender: byte stream in, same bytes out with an MSB-first CRC appended after each frame.
// Latency: one cycle from input accept to o_m_data; NBYTES CRC bytes follow the frame's last data byte.
// Backpressure: single registered output stage; o_s_ready = output free and not appending a CRC.
// Ports: i_clk / i_reset_n (async, active-low); i_s_data/i_s_valid/i_s_last/o_s_ready input stream;
//   o_m_data/o_m_valid/o_m_last/i_m_ready output stream (o_m_last on final CRC byte);
//   o_frame_cnt counts frames whose last CRC byte was accepted downstream, wrapping at 0xFFFF.
module crc_frame_appender #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = 'h07,
  parameter logic [CRC_WIDTH-1:0] INIT      = 'h00,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 'h00
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_s_data,
  input  logic        i_s_valid,
  input  logic        i_s_last,
  output logic        o_s_ready,
  output logic [7:0]  o_m_data,
  output logic        o_m_valid,
  output logic        o_m_last,
  input  logic        i_m_ready,
  output logic [15:0] o_frame_cnt
);

  localparam int         NBYTES   = CRC_WIDTH / 8;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  typedef enum logic {ST_DATA, ST_APPEND} state_t;

  state_t               r_state, w_state_nxt;
  logic [CRC_WIDTH-1:0] r_crc, r_fcrc;
  logic [CRC_WIDTH-1:0] w_crc_upd, w_fcrc_sh;
  logic [1:0]           r_idx;
  logic [7:0]           r_m_data;
  logic                 r_m_valid, r_m_last;
  logic [15:0]          r_frame_cnt;
  logic [7:0]           w_crc_byte;
  logic                 w_ofree, w_accept, w_load_crc, w_last_crc, w_pop_last;

  // Serial MSB-first CRC over one byte, bit 7 first, no reflection.
  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [7:0]           d);
    logic [CRC_WIDTH-1:0] x;
    logic                 fb;
    x = c;
    for (int b = 7; b >= 0; b--) begin
      fb = x[CRC_WIDTH-1] ^ d[b];
      x  = {x[CRC_WIDTH-2:0], 1'b0};
      if (fb) x = x ^ POLY;
    end
    return x;
  endfunction

  assign w_crc_upd  = crc_byte(r_crc, i_s_data);
  // Select the CRC byte for the current index, most-significant byte first.
  assign w_fcrc_sh  = r_fcrc >> (8 * (NBYTES - 1 - int'(r_idx)));
  assign w_crc_byte = w_fcrc_sh[7:0];
  assign w_pop_last = r_m_valid && i_m_ready && r_m_last;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_DATA;
    else            r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DATA:   if (w_accept && i_s_last) w_state_nxt = ST_APPEND;
      ST_APPEND: if (w_last_crc)           w_state_nxt = ST_DATA;
      default:                             w_state_nxt = ST_DATA;
    endcase
  end

  // FSM: outputs / strobes
  always_comb begin
    w_ofree    = !r_m_valid || i_m_ready;
    o_s_ready  = 1'b0;
    w_load_crc = 1'b0;
    case (r_state)
      ST_DATA:   o_s_ready  = w_ofree;
      ST_APPEND: w_load_crc = w_ofree;
      default:   o_s_ready  = 1'b0;
    endcase
    w_accept   = i_s_valid && o_s_ready;
    w_last_crc = w_load_crc && (r_idx == LAST_IDX);
  end

  // Output register, running CRC, frame CRC latch and byte index.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_crc     <= INIT;
      r_fcrc    <= '0;
      r_idx     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_accept) begin
      r_m_data  <= i_s_data;
      r_m_valid <= 1'b1;
      r_m_last  <= 1'b0;
      r_crc     <= w_crc_upd;
      if (i_s_last) begin
        r_fcrc <= w_crc_upd ^ XOR_OUT;
        r_idx  <= '0;
      end
    end else if (w_load_crc) begin
      r_m_data  <= w_crc_byte;
      r_m_valid <= 1'b1;
      r_m_last  <= w_last_crc;
      if (w_last_crc) begin
        r_crc <= INIT;
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end else if (w_ofree) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)      r_frame_cnt <= '0;
    else if (w_pop_last) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign o_m_data    = r_m_data;
  assign o_m_valid   = r_m_valid;
  assign o_m_last    = r_m_last;
  assign o_frame_cnt = r_frame_cnt;

endmodule
